// File: rtl/jtframe_nvram_lanes.sv
// Dual-port byte-lane NVRAM with a built-in dump/load streaming engine and dirty tracking.
// Reads take 1 cycle on both ports. The dump stream holds so_valid/so_data until so_ready; the load stream accepts one byte per si_valid.
module jtframe_nvram_lanes #(
    parameter int LANES   = 2,
    parameter int AW      = 10,
    parameter     SIMFILE = ""
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [AW-1:0]             addr0,
    input  logic [8*LANES-1:0]        din0,
    input  logic [LANES-1:0]          we0,
    output logic [8*LANES-1:0]        dout0,
    input  logic [AW+$clog2(LANES)-1:0] addr1,
    input  logic [7:0]                din1,
    input  logic                      we1,
    output logic [7:0]                dout1,
    input  logic                      xfer_start,
    input  logic                      xfer_load,
    output logic                      busy,
    output logic                      dirty,
    output logic [7:0]                so_data,
    output logic                      so_valid,
    input  logic                      so_ready,
    input  logic [7:0]                si_data,
    input  logic                      si_valid,
    output logic                      si_ready
);

    localparam int LB    = $clog2(LANES);
    localparam int LBW   = (LB == 0) ? 1 : LB;
    localparam int BW    = AW + LB;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, FETCH, SHOW, LOAD} state_t;

    state_t        state;
    logic [BW-1:0] cnt;

    logic [BW-1:0]  p1_addr;
    logic [AW-1:0]  p1_word;
    logic [LBW-1:0] p1_lane;
    logic           p1_we;
    logic [7:0]     p1_din;
    logic           eng_we;

    logic [7:0] rd0 [LANES];
    logic [7:0] rd1 [LANES];

    // Port 1 is handed to the engine for the whole transfer; writes are held off in reset so an abort never corrupts memory.
    assign eng_we  = (state == LOAD) && si_valid && rst_n;
    assign p1_addr = busy ? cnt : addr1;
    assign p1_we   = busy ? eng_we : (we1 && rst_n);
    assign p1_din  = busy ? si_data : din1;

    if (LB == 0) begin : g_single_lane
        assign p1_word = p1_addr;
        assign p1_lane = '0;
    end else begin : g_multi_lane
        assign p1_word = p1_addr[BW-1:LB];
        assign p1_lane = p1_addr[LB-1:0];
    end

    // The simulation preload image is applied hierarchically by the harness into g_lane[*].mem.
    if (SIMFILE != "") begin : g_simfile
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic       wr1;

        // Port 0 owns a byte both ports hit in the same cycle.
        assign wr1 = p1_we && (p1_lane == LBW'(l)) && !(we0[l] && (addr0 == p1_word));

        always_ff @(posedge clk) begin
            if (we0[l]) mem[addr0] <= din0[8*l +: 8];
            if (wr1)    mem[p1_word] <= p1_din;
        end

        assign rd0[l] = mem[addr0];
        assign rd1[l] = mem[p1_word];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            dirty    <= 1'b0;
            so_valid <= 1'b0;
            so_data  <= '0;
            si_ready <= 1'b0;
            dout0    <= '0;
            dout1    <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                dout0[8*l +: 8] <= rd0[l];
            end
            if (!busy) dout1 <= rd1[p1_lane];

            // A CPU write in the same cycle as a transfer start keeps the flag set.
            if (|we0) begin
                dirty <= 1'b1;
            end else if (state == IDLE && xfer_start) begin
                dirty <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (xfer_start) begin
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (xfer_load) begin
                            state    <= LOAD;
                            si_ready <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    so_data  <= rd1[p1_lane];
                    so_valid <= 1'b1;
                    state    <= SHOW;
                end
                SHOW: begin
                    if (so_ready) begin
                        so_valid <= 1'b0;
                        if (cnt == '1) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt   <= cnt + BW'(1);
                            state <= FETCH;
                        end
                    end
                end
                LOAD: begin
                    if (si_valid) begin
                        if (cnt == '1) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            si_ready <= 1'b0;
                        end else begin
                            cnt <= cnt + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
